// File: rtl/l1_mem_arbiter_if.sv
// Bundle of the two L1 cache request ports and the shared memory port.
// Handshake: a cache holds read/write (level) with addr/wdata stable until
// its ready pulse; memory sees one registered request and answers with a
// single-cycle mem_ready, rdata valid while mem_ready is high.
interface l1_mem_arbiter_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic              c0_read;
   logic              c0_write;
   logic [ADDR_W-1:0] c0_addr;
   logic [DATA_W-1:0] c0_wdata;
   logic              c0_ready;
   logic [DATA_W-1:0] c0_rdata;
   logic              c1_read;
   logic              c1_write;
   logic [ADDR_W-1:0] c1_addr;
   logic [DATA_W-1:0] c1_wdata;
   logic              c1_ready;
   logic [DATA_W-1:0] c1_rdata;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   // Arbiter view
   modport slave (
      input  c0_read, c0_write, c0_addr, c0_wdata,
      input  c1_read, c1_write, c1_addr, c1_wdata,
      input  mem_rdata, mem_ready,
      output c0_ready, c0_rdata, c1_ready, c1_rdata,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   // Environment view (caches plus memory)
   modport master (
      output c0_read, c0_write, c0_addr, c0_wdata,
      output c1_read, c1_write, c1_addr, c1_wdata,
      output mem_rdata, mem_ready,
      input  c0_ready, c0_rdata, c1_ready, c1_rdata,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Two-port arbiter sharing one memory port between the L1 I-cache (port 0)
// and the L1 D-cache (port 1). One transaction at a time, request registered
// onto the memory bus, mem_ready routed only to the owning port.
module l1_mem_arbiter #(
   parameter int ADDR_W     = 30,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic                clk,
   input  logic                proc_reset_n,
   l1_mem_arbiter_if.slave     bus,
   output logic [1:0]          state_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY0 = 2'd1,
      S_BUSY1 = 2'd2
   } state_t;

   state_t            state_q;
   logic              last_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic              req0;
   logic              req1;
   logic              win_d;
   logic              sel_read_d;
   logic              sel_write_d;
   logic [ADDR_W-1:0] sel_addr_d;
   logic [DATA_W-1:0] sel_wdata_d;

   // Pick the winning port and mux its request; write dominates read.
   always_comb begin
      req0 = bus.c0_read | bus.c0_write;
      req1 = bus.c1_read | bus.c1_write;
      if (req0 && req1) begin
         win_d = (FIXED_PRIO != 0) ? 1'b1 : ~last_q;
      end else begin
         win_d = req1;
      end
      if (win_d) begin
         sel_write_d = bus.c1_write;
         sel_read_d  = bus.c1_read & ~bus.c1_write;
         sel_addr_d  = bus.c1_addr;
         sel_wdata_d = bus.c1_wdata;
      end else begin
         sel_write_d = bus.c0_write;
         sel_read_d  = bus.c0_read & ~bus.c0_write;
         sel_addr_d  = bus.c0_addr;
         sel_wdata_d = bus.c0_wdata;
      end
   end

   // Ownership FSM with the registered memory request.
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q     <= S_IDLE;
         last_q      <= 1'b1;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // mem_ready here is spurious and deliberately ignored
               if (req0 || req1) begin
                  last_q      <= win_d;
                  state_q     <= win_d ? S_BUSY1 : S_BUSY0;
                  mem_read_q  <= sel_read_d;
                  mem_write_q <= sel_write_d;
                  mem_addr_q  <= sel_addr_d;
                  mem_wdata_q <= sel_wdata_d;
               end
            end
            S_BUSY0, S_BUSY1: begin
               // Cache inputs are ignored while busy; only completion matters.
               if (bus.mem_ready) begin
                  state_q     <= S_IDLE;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // Completion strobe goes to the owner in the same cycle as mem_ready.
   assign bus.c0_ready  = bus.mem_ready & (state_q == S_BUSY0);
   assign bus.c1_ready  = bus.mem_ready & (state_q == S_BUSY1);
   assign bus.c0_rdata  = bus.mem_rdata;
   assign bus.c1_rdata  = bus.mem_rdata;

   assign state_o = state_q;

endmodule
